// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and constants for the two-digit BCD countdown timer.
package bcd_countdown_timer_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned ACNT_W  = 8;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    ALARM = 2'b11
  } state_t;

  // Out-of-range preset digits saturate at 9 so the display never sees A-F.
  function automatic logic [DIGIT_W-1:0] clamp_bcd(input logic [DIGIT_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control and display bundle between the timer and its host/display path.
interface bcd_countdown_timer_if;
  import bcd_countdown_timer_pkg::*;

  logic               load;
  logic [DIGIT_W-1:0] preset_tens;
  logic [DIGIT_W-1:0] preset_units;
  logic               run;
  logic [DIGIT_W-1:0] tens;
  logic [DIGIT_W-1:0] units;
  logic               alarm;
  logic               done;
  state_t             state;

  modport master (
    output load, preset_tens, preset_units, run,
    input  tens, units, alarm, done, state
  );

  modport slave (
    input  load, preset_tens, preset_units, run,
    output tens, units, alarm, done, state
  );

endinterface

// File: rtl/bcd_countdown_timer_bcd_dec2.sv
// Two-digit BCD decrement with borrow, plus 00/01 detection.
module bcd_dec2
  import bcd_countdown_timer_pkg::*;
(
  input  logic [DIGIT_W-1:0] tens,
  input  logic [DIGIT_W-1:0] units,
  output logic [DIGIT_W-1:0] dec_tens,
  output logic [DIGIT_W-1:0] dec_units,
  output logic               is_one,
  output logic               is_zero
);

  always_comb begin
    dec_tens  = tens;
    dec_units = units - 4'd1;
    is_zero   = (tens == 4'd0) && (units == 4'd0);
    is_one    = (tens == 4'd0) && (units == 4'd1);
    // Units borrow from tens; 00 wraps to 99 to stay valid BCD.
    if (units == 4'd0) begin
      dec_units = BCD_MAX;
      dec_tens  = (tens == 4'd0) ? BCD_MAX : tens - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer on the 1 s tick with a blinking alarm phase.
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter int unsigned ALARM_SECS = 4
) (
  input  logic                  clk_1s,
  input  logic                  reset,
  bcd_countdown_timer_if.slave  bus
);

  localparam logic [ACNT_W-1:0] ACNT_LAST = ACNT_W'(ALARM_SECS - 1);

  state_t             state_q, state_d;
  logic [DIGIT_W-1:0] tens_q, tens_d, units_q, units_d;
  logic [DIGIT_W-1:0] dec_tens, dec_units;
  logic [ACNT_W-1:0]  acnt_q, acnt_d;
  logic               alarm_q, alarm_d;
  logic               done_q, done_d;
  logic               is_one, is_zero;

  bcd_dec2 u_dec (
    .tens      (tens_q),
    .units     (units_q),
    .dec_tens  (dec_tens),
    .dec_units (dec_units),
    .is_one    (is_one),
    .is_zero   (is_zero)
  );

  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tens_q  <= '0;
      units_q <= '0;
      acnt_q  <= '0;
      alarm_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      acnt_q  <= acnt_d;
      alarm_q <= alarm_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic; load overrides every state.
  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    units_d = units_q;
    acnt_d  = acnt_q;
    alarm_d = alarm_q;
    done_d  = 1'b0;

    if (bus.load) begin
      tens_d  = clamp_bcd(bus.preset_tens);
      units_d = clamp_bcd(bus.preset_units);
      state_d = IDLE;
      alarm_d = 1'b0;
      acnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.run && !is_zero) state_d = RUN;
        end
        RUN: begin
          if (!bus.run) begin
            state_d = PAUSE;
          end else if (is_one) begin
            tens_d  = '0;
            units_d = '0;
            state_d = ALARM;
            done_d  = 1'b1;
            alarm_d = 1'b1;
            acnt_d  = '0;
          end else begin
            tens_d  = dec_tens;
            units_d = dec_units;
          end
        end
        PAUSE: begin
          if (bus.run) state_d = RUN;
        end
        ALARM: begin
          if (acnt_q == ACNT_LAST) begin
            state_d = IDLE;
            alarm_d = 1'b0;
          end else begin
            acnt_d  = acnt_q + 8'd1;
            alarm_d = ~alarm_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.tens  = tens_q;
  assign bus.units = units_q;
  assign bus.alarm = alarm_q;
  assign bus.done  = done_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed plus randomized checks of bcd_countdown_timer against a count-based reference model.
module tb_bcd_countdown_timer;

  localparam int ALARM_SECS = 4;
  localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_PAUSE = 2'b10, S_ALARM = 2'b11;

  logic clk_1s = 1'b0;
  logic reset  = 1'b1;
  int   errors = 0;
  int   checks = 0;

  // Reference model: count as a plain integer 0..99, seconds spent in alarm.
  int         m_count = 0;
  logic [1:0] m_state = S_IDLE;
  int         m_k     = 0;
  logic       m_done  = 1'b0;

  bcd_countdown_timer_if bus ();

  bcd_countdown_timer #(.ALARM_SECS(ALARM_SECS)) dut (
    .clk_1s (clk_1s),
    .reset  (reset),
    .bus    (bus)
  );

  initial forever #5 clk_1s = ~clk_1s;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int min9(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  task automatic check_all(input string tag);
    logic exp_alarm;
    exp_alarm = (m_state == S_ALARM) && (m_k % 2 == 0);
    check({tag, ".tens"},  8'(bus.tens),  8'(m_count / 10));
    check({tag, ".units"}, 8'(bus.units), 8'(m_count % 10));
    check({tag, ".state"}, 8'(bus.state), 8'(m_state));
    check({tag, ".alarm"}, 8'(bus.alarm), 8'(exp_alarm));
    check({tag, ".done"},  8'(bus.done),  8'(m_done));
    check({tag, ".bcd_ok"}, 8'((bus.tens <= 4'd9) && (bus.units <= 4'd9)), 8'd1);
  endtask

  task automatic model_edge(input logic ld, input logic [3:0] pt, input logic [3:0] pu,
                            input logic rn);
    m_done = 1'b0;
    if (ld) begin
      m_count = min9(pt) * 10 + min9(pu);
      m_state = S_IDLE;
      m_k     = 0;
    end else begin
      case (m_state)
        S_IDLE:  if (rn && m_count != 0) m_state = S_RUN;
        S_RUN: begin
          if (!rn) m_state = S_PAUSE;
          else begin
            m_count = m_count - 1;
            if (m_count == 0) begin
              m_state = S_ALARM;
              m_k     = 0;
              m_done  = 1'b1;
            end
          end
        end
        S_PAUSE: if (rn) m_state = S_RUN;
        default: begin
          m_k = m_k + 1;
          if (m_k == ALARM_SECS) m_state = S_IDLE;
        end
      endcase
    end
  endtask

  task automatic step(input string tag, input logic ld, input logic [3:0] pt,
                      input logic [3:0] pu, input logic rn);
    bus.load         = ld;
    bus.preset_tens  = pt;
    bus.preset_units = pu;
    bus.run          = rn;
    @(posedge clk_1s);
    model_edge(ld, pt, pu, rn);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse placed between edges; outputs must clear without a clock.
  task automatic async_reset(input string tag);
    reset = 1'b1;
    #1;
    m_count = 0; m_state = S_IDLE; m_k = 0; m_done = 1'b0;
    check_all(tag);
    reset = 1'b0;
  endtask

  initial begin
    bus.load = 1'b0; bus.preset_tens = '0; bus.preset_units = '0; bus.run = 1'b0;
    #2;
    check_all("reset");
    reset = 1'b0;

    // Basic countdown from 03 through the alarm phase back to idle.
    step("basic_load", 1'b1, 4'd0, 4'd3, 1'b0);
    for (int i = 0; i < 4; i++) step("basic_run", 1'b0, 4'd0, 4'd0, 1'b1);
    check("basic_done_at_00", 8'(bus.done), 8'd1);
    for (int i = 0; i < 5; i++) step("basic_alarm", 1'b0, 4'd0, 4'd0, 1'b1);
    check("basic_back_idle", 8'(bus.state), 8'(S_IDLE));

    // 10 -> 09 borrow.
    step("borrow_load", 1'b1, 4'd1, 4'd0, 1'b0);
    step("borrow_enter", 1'b0, 4'd0, 4'd0, 1'b1);
    step("borrow_dec", 1'b0, 4'd0, 4'd0, 1'b1);
    check("borrow_units", 8'(bus.units), 8'd9);

    // Pause at 23 for three edges, then resume.
    step("pause_load", 1'b1, 4'd2, 4'd5, 1'b0);
    for (int i = 0; i < 3; i++) step("pause_run", 1'b0, 4'd0, 4'd0, 1'b1);
    for (int i = 0; i < 3; i++) step("pause_hold", 1'b0, 4'd0, 4'd0, 1'b0);
    step("pause_resume", 1'b0, 4'd0, 4'd0, 1'b1);
    step("pause_dec", 1'b0, 4'd0, 4'd0, 1'b1);
    check("pause_22_units", 8'(bus.units), 8'd2);

    // Reset mid-RUN.
    async_reset("reset_mid_run");

    // Clamp, then 00 preset with run already high (load wins on that edge).
    step("clamp_load", 1'b1, 4'd12, 4'd15, 1'b1);
    step("zero_load", 1'b1, 4'd0, 4'd0, 1'b1);
    step("zero_stay", 1'b0, 4'd0, 4'd0, 1'b1);
    step("zero_stay2", 1'b0, 4'd0, 4'd0, 1'b1);

    // Load during ALARM.
    step("lp_load", 1'b1, 4'd0, 4'd1, 1'b0);
    step("lp_enter", 1'b0, 4'd0, 4'd0, 1'b1);
    step("lp_alarm", 1'b0, 4'd0, 4'd0, 1'b1);
    step("lp_alarm2", 1'b0, 4'd0, 4'd0, 1'b0);
    step("lp_load_in_alarm", 1'b1, 4'd0, 4'd5, 1'b1);

    // Reset mid-ALARM.
    step("ra_load", 1'b1, 4'd0, 4'd1, 1'b0);
    step("ra_enter", 1'b0, 4'd0, 4'd0, 1'b1);
    step("ra_alarm", 1'b0, 4'd0, 4'd0, 1'b1);
    async_reset("reset_mid_alarm");

    // Full 99 countdown exercises the 90->89 borrow.
    step("full_load", 1'b1, 4'd9, 4'd9, 1'b0);
    for (int i = 0; i < 105; i++) step("full_run", 1'b0, 4'd0, 4'd0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic       ld, rn;
      logic [3:0] pt, pu;
      ld = ($urandom_range(0, 19) == 0);
      rn = ($urandom_range(0, 7) != 0);
      pt = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 1));
      pu = 4'($urandom_range(0, 15));
      step("rand", ld, pt, pu, rn);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
Two-digit BCD countdown timer (preset 00–99) clocked by the 1 s tick.
- Sits in the same display path as the 0–99 up-counter.
- Its tens and units digits feed the existing seven-segment decoders directly, so no divide/modulo stage is needed.
- On reaching 00 it drives a blinking alarm LED for a fixed number of seconds, then returns to idle.

Parameters:
ALARM_SECS, 4, number of clk_1s cycles spent in ALARM (legal range 1..255)

Ports:
clk_1s        input   1  1 Hz timing clock; all state changes on its rising edge
reset         input   1  asynchronous, active-high reset
load          input   1  level, sampled each edge; loads preset digits
preset_tens   input   4  BCD tens preset
preset_units  input   4  BCD units preset
run           input   1  level; 1 = count, 0 = pause
tens          output  4  BCD tens digit, to seven-segment decoder
units         output  4  BCD units digit, to seven-segment decoder
alarm         output  1  LED drive; blinks while in ALARM
done          output  1  one-cycle pulse on the edge the count reaches 00
state         output  2  current FSM state, for debug

Behaviour:
Reset (asynchronous, immediate):
- state=IDLE, tens=0, units=0, alarm=0, done=0, internal alarm counter=0.

State encoding: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, ALARM=2'b11.

Priority on each edge: load > state-specific action.

Load:
- If load=1 in any state: tens/units ← preset, with each digit clamped to 9 if greater than 9.
- Also: state ← IDLE, alarm ← 0, alarm counter ← 0, done ← 0.
- run is ignored on that edge.

IDLE:
- If run=1 and {tens,units}≠00: state ← RUN. No decrement on this edge.
- Otherwise hold. run=1 with a count of 00 stays in IDLE.

RUN:
- If run=0: state ← PAUSE; count holds.
- Else if count==01: count ← 00, state ← ALARM, done ← 1, alarm ← 1, alarm counter ← 0.
- Else decrement by one in BCD:
  - units==0 → units ← 9, tens ← tens−1.
  - otherwise units ← units−1.

PAUSE:
- If run=1: state ← RUN. No decrement on this edge.
- Else hold.

ALARM:
- run is ignored; count holds at 00.
- If alarm counter == ALARM_SECS−1: state ← IDLE, alarm ← 0.
- Else: alarm counter +1, alarm ← ~alarm.
- ALARM therefore lasts exactly ALARM_SECS cycles. Example: with ALARM_SECS=4 the alarm output sequence is 1,0,1,0, then 0 in IDLE.

done:
- Registered; high for exactly one clk_1s cycle, only on the RUN→ALARM edge.
- Cleared on every other edge.

Latency and widths:
- All outputs are registered; no combinational path from inputs to outputs.
- Alarm counter is 8 bits.

Boundary conditions:
- Preset 99 counts 99→98…→00 with correct 90→89 and 10→09 borrows.
- A run toggle in the same cycle as load has no effect; load wins.
- Reset asserted mid-RUN or mid-ALARM clears everything immediately, without waiting for an edge.
- tens and units never hold a value above 9.

Decomposition:
- Shared package:
  - FSM state localparams (IDLE/RUN/PAUSE/ALARM).
  - BCD_MAX=4'd9.
  - Width constant for the alarm counter.
- One combinational sub-module, bcd_dec2:
  - Inputs: tens, units. Outputs: decremented tens, units, and is_one / is_zero flags.
  - Keeps the FSM file to state/control logic only.

Test Plan:
- Reset mid-count: assert reset asynchronously mid-RUN → all outputs 0 and state=IDLE before the next clk_1s edge.
- Basic countdown:
  - Stimulus: load preset 0,3 → run=1.
  - Required response: edge1 state=RUN with count 03, then 02, 01, 00.
  - At 00: done=1 for one cycle; alarm 1,0,1,0; then IDLE with alarm=0 and count 00.
- Borrow: load preset 1,0, run=1 → after the entry edge, next edge shows 0,9; the 10→09 borrow is correct.
- Pause/resume:
  - Stimulus: load 2,5 → run; drop run when count is 23.
  - Required response: state=PAUSE, count stays 23 for 3 edges.
  - Raise run → one edge at 23 in RUN, then 22.
- Clamp and zero preset:
  - Load preset 12,15 → count 9,9.
  - Load 0,0 with run=1 → stays IDLE at 00 with done=0.
- Load priority in ALARM: assert load with preset 0,5 during ALARM → next edge: IDLE, count 05, alarm=0, done=0.
